// File: rtl/tybec_pkg.sv
// Shared TyBEC definitions: FloPoCo exception codes, core selectors, per-core
// latencies and behavioural stand-ins for the FloPoCo 8/23 arithmetic cores.
package tybec_pkg;

  localparam logic [1:0] FPC_EF_ZERO   = 2'b00;
  localparam logic [1:0] FPC_EF_NORMAL = 2'b01;
  localparam logic [1:0] FPC_EF_INF    = 2'b10;
  localparam logic [1:0] FPC_EF_NAN    = 2'b11;

  localparam int OP_DIV = 0;
  localparam int OP_MUL = 1;
  localparam int OP_ADD = 2;

  localparam int LAT_DIV = 13;
  localparam int LAT_MUL = 3;
  localparam int LAT_ADD = 6;

  // Pack a result, turning exponent overflow into INF and underflow into ZERO.
  function automatic logic [33:0] fpc_pack(input logic [1:0] ef, input logic s,
                                           input logic signed [9:0] e, input logic [22:0] m);
    if (ef != FPC_EF_NORMAL) return {ef, s, 31'd0};
    else if (e >= 10'sd255) return {FPC_EF_INF, s, 31'd0};
    else if (e <= 10'sd0) return {FPC_EF_ZERO, s, 31'd0};
    else return {FPC_EF_NORMAL, s, e[7:0], m};
  endfunction

  // Truncating multiply; keeps product bits [47:23] of the 24x24 mantissa product.
  function automatic logic [33:0] fpc_mul(input logic [33:0] a, input logic [33:0] b);
    logic [1:0] ea, eb, ef;
    logic [24:0] p;
    logic signed [9:0] e;
    logic [22:0] m;
    ea = a[33:32];
    eb = b[33:32];
    p = 25'(({24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]}) >> 23);
    e = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
    if (p[24]) begin
      m = p[23:1];
      e = e + 10'sd1;
    end else begin
      m = p[22:0];
    end
    if (ea == FPC_EF_NAN || eb == FPC_EF_NAN ||
        (ea == FPC_EF_ZERO && eb == FPC_EF_INF) || (ea == FPC_EF_INF && eb == FPC_EF_ZERO))
      ef = FPC_EF_NAN;
    else if (ea == FPC_EF_INF || eb == FPC_EF_INF) ef = FPC_EF_INF;
    else if (ea == FPC_EF_ZERO || eb == FPC_EF_ZERO) ef = FPC_EF_ZERO;
    else ef = FPC_EF_NORMAL;
    return fpc_pack(ef, a[31] ^ b[31], e, m);
  endfunction

  // Truncating divide; the 25-bit quotient of (ma << 24) / mb lies in (2^23, 2^25).
  function automatic logic [33:0] fpc_div(input logic [33:0] a, input logic [33:0] b);
    logic [1:0] ea, eb, ef;
    logic [24:0] q;
    logic signed [9:0] e;
    logic [22:0] m;
    ea = a[33:32];
    eb = b[33:32];
    q = 25'({1'b1, a[22:0], 24'd0} / {24'd0, 1'b1, b[22:0]});
    e = $signed({2'b00, a[30:23]}) - $signed({2'b00, b[30:23]}) + 10'sd127;
    if (q[24]) begin
      m = q[23:1];
    end else begin
      m = q[22:0];
      e = e - 10'sd1;
    end
    if (ea == FPC_EF_NAN || eb == FPC_EF_NAN ||
        (ea == FPC_EF_ZERO && eb == FPC_EF_ZERO) || (ea == FPC_EF_INF && eb == FPC_EF_INF))
      ef = FPC_EF_NAN;
    else if (ea == FPC_EF_INF || eb == FPC_EF_ZERO) ef = FPC_EF_INF;
    else if (ea == FPC_EF_ZERO || eb == FPC_EF_INF) ef = FPC_EF_ZERO;
    else ef = FPC_EF_NORMAL;
    return fpc_pack(ef, a[31] ^ b[31], e, m);
  endfunction

  // Truncating add with one guard bit; x is the operand of larger magnitude.
  function automatic logic [33:0] fpc_add(input logic [33:0] a, input logic [33:0] b);
    logic [31:0] x, y;
    logic [7:0] d;
    logic [25:0] mx, my, sum;
    logic signed [9:0] e;
    logic [22:0] m;
    if (a[30:0] >= b[30:0]) begin
      x = a[31:0];
      y = b[31:0];
    end else begin
      x = b[31:0];
      y = a[31:0];
    end
    d = x[30:23] - y[30:23];
    mx = {2'b01, x[22:0], 1'b0};
    my = (d > 8'd25) ? 26'd0 : ({2'b01, y[22:0], 1'b0} >> d);
    sum = (x[31] == y[31]) ? mx + my : mx - my;
    e = $signed({2'b00, x[30:23]});
    if (sum[25]) begin
      m = sum[24:2];
      e = e + 10'sd1;
    end else begin
      for (int i = 0; i < 25; i++) begin
        if (!sum[24] && sum != 26'd0) begin
          sum = sum << 1;
          e = e - 10'sd1;
        end
      end
      m = sum[23:1];
    end
    if (a[33:32] == FPC_EF_NAN || b[33:32] == FPC_EF_NAN ||
        (a[33:32] == FPC_EF_INF && b[33:32] == FPC_EF_INF && a[31] != b[31]))
      return {FPC_EF_NAN, 32'd0};
    else if (a[33:32] == FPC_EF_INF) return a;
    else if (b[33:32] == FPC_EF_INF) return b;
    else if (a[33:32] == FPC_EF_ZERO) return b;
    else if (b[33:32] == FPC_EF_ZERO) return a;
    else if (sum == 26'd0) return {FPC_EF_ZERO, 32'd0};
    else return fpc_pack(FPC_EF_NORMAL, x[31], e, m);
  endfunction

endpackage

// File: rtl/tybec_sync_fifo.sv
// Synchronous first-word-fall-through FIFO. Pointers carry one extra bit so
// full and empty are distinguishable; the head reads as zero while empty.
module tybec_sync_fifo #(
  parameter int W     = 34,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_wr_en,
  input  logic [W-1:0]             i_wr_data,
  input  logic                     i_rd_en,
  output logic [W-1:0]             o_rd_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic         w_wr;
  logic         w_rd;

  assign w_wr      = i_wr_en & ~o_full;
  assign w_rd      = i_rd_en & ~o_empty;
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_count   = r_wr_ptr - r_rd_ptr;
  assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  // Advance pointers on write/read; reset empties the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // Storage array, written at the tail.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
  end

endmodule

// File: rtl/tybec_map_node_fp2.sv
// Two-operand TyBEC leaf map node around a fixed-latency floating-point core.
// Handshake: a token moves on an interface in any cycle where its valid and
// ready are both high; valid never depends on ready, and ready on the input
// side depends only on registered credit state, never on oready.
module tybec_map_node_fp2
  import tybec_pkg::*;
#(
  parameter int                 STREAMW    = 34,
  parameter int                 OP         = 0,
  parameter int                 LAT        = LAT_DIV,
  parameter int                 FIFO_DEPTH = 16,
  parameter int                 IN2_CONST  = 1,
  parameter logic [STREAMW-1:0] IN2_VALUE  = 34'h1_447a0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ivalid_in1,
  input  logic [STREAMW-1:0] in1,
  input  logic               ivalid_in2,
  input  logic [STREAMW-1:0] in2,
  output logic               iready,
  output logic               ovalid,
  output logic [STREAMW-1:0] out1,
  input  logic               oready
);
  localparam int UW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [UW-1:0] DEPTH_U = UW'(FIFO_DEPTH);
  localparam int LAT_EXP = (OP == OP_DIV) ? LAT_DIV : (OP == OP_MUL) ? LAT_MUL : LAT_ADD;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("tybec_map_node_fp2: FIFO_DEPTH must be a power of two >= 2");
  end
  if (OP < 0 || OP > 2) begin : g_bad_op
    $error("tybec_map_node_fp2: OP must be 0, 1 or 2");
  end
  if (STREAMW != 34 || LAT != LAT_EXP) begin : g_bad_core
    $error("tybec_map_node_fp2: STREAMW/LAT do not match the selected core");
  end

  logic               r_iready;
  logic [UW-1:0]      r_used;
  logic [STREAMW-1:0] r_a;
  logic [STREAMW-1:0] r_b;
  logic [LAT:0]       r_vsh;
  logic [STREAMW-1:0] r_pipe [LAT];
  logic               w_accept;
  logic               w_pop;
  logic [UW-1:0]      w_used_next;
  logic [STREAMW-1:0] w_core_comb;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic [UW-1:0]      w_fifo_count;

  assign w_accept    = ivalid_in1 & ((IN2_CONST != 0) | ivalid_in2) & r_iready;
  assign w_pop       = ovalid & oready;
  assign w_used_next = r_used + UW'(w_accept) - UW'(w_pop);
  assign iready      = r_iready;
  assign ovalid      = ~w_fifo_empty;

  // Credits cover in-flight plus buffered tokens; ready is their registered headroom.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_used   <= '0;
      r_iready <= 1'b0;
    end else begin
      r_used   <= w_used_next;
      r_iready <= (w_used_next < DEPTH_U);
    end
  end

  // Operand capture on accept and a valid tag that travels alongside the core.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_vsh <= '0;
    end else begin
      r_vsh <= {r_vsh[LAT-1:0], w_accept};
      if (w_accept) begin
        r_a <= in1;
        r_b <= (IN2_CONST != 0) ? IN2_VALUE : in2;
      end
    end
  end

  // Core selection: combinational arithmetic feeding a never-stalled pipeline.
  case (OP)
    OP_DIV:  begin : g_div assign w_core_comb = fpc_div(r_a, r_b); end
    OP_MUL:  begin : g_mul assign w_core_comb = fpc_mul(r_a, r_b); end
    default: begin : g_add assign w_core_comb = fpc_add(r_a, r_b); end
  endcase

  // Core pipeline registers; only the valid tag needs resetting.
  always_ff @(posedge clk) begin
    r_pipe[0] <= w_core_comb;
    for (int i = 1; i < LAT; i++) r_pipe[i] <= r_pipe[i-1];
  end

  tybec_sync_fifo #(
    .W     (STREAMW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .i_wr_en   (r_vsh[LAT]),
    .i_wr_data (r_pipe[LAT-1]),
    .i_rd_en   (oready),
    .o_rd_data (out1),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty),
    .o_count   (w_fifo_count)
  );

  // Credit accounting guarantees a core result always finds room in the FIFO.
  always_ff @(posedge clk) begin
    assert (!(r_vsh[LAT] && w_fifo_full));
    assert (w_fifo_count <= r_used);
  end

endmodule
